// File: rtl/std_cache_pkg.sv
// Shared dcache types and sizing used by the valid/dirty init sequencer.
package std_cache_pkg;

  localparam int unsigned DCACHE_NUM_WORDS = 256;
  localparam int unsigned DCACHE_SET_ASSOC = 8;

  typedef struct packed {
    logic valid;
    logic dirty;
  } vldrty_t;

  typedef enum logic [1:0] {
    StClear,
    StIdle,
    StDrain
  } vldrty_init_state_e;

endpackage

// File: rtl/dcache_vldrty_init.sv
// Clears the valid/dirty SRAM one index per cycle after reset or on request,
// otherwise passes arbiter traffic straight through to the macro.
module dcache_vldrty_init
  import std_cache_pkg::*;
#(
  parameter int unsigned NumWords = DCACHE_NUM_WORDS,
  parameter int unsigned SetAssoc = DCACHE_SET_ASSOC,
  localparam int unsigned AddrWidth = $clog2(NumWords)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          init_i,
  input  logic [SetAssoc-1:0]           up_req_i,
  input  logic                          up_we_i,
  input  logic [AddrWidth-1:0]          up_addr_i,
  input  vldrty_t [SetAssoc-1:0]        up_wdata_i,
  input  vldrty_t [SetAssoc-1:0]        up_be_i,
  output logic                          up_gnt_o,
  output logic [SetAssoc-1:0]           ram_req_o,
  output logic                          ram_we_o,
  output logic [AddrWidth-1:0]          ram_addr_o,
  output vldrty_t [SetAssoc-1:0]        ram_wdata_o,
  output vldrty_t [SetAssoc-1:0]        ram_be_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam logic [AddrWidth-1:0] LastIdx = AddrWidth'(NumWords - 1);

  vldrty_init_state_e   state_q;
  logic [AddrWidth-1:0] cnt_q;
  logic                 init_q;
  logic                 last_idx;
  logic                 restart;

  assign last_idx = (cnt_q == LastIdx);
  // Only a fresh assertion restarts a running clear, so a held init_i still
  // lets each sequence finish and yields one clear per visit to idle.
  assign restart  = init_i & ~init_q;

  always_ff @(posedge clk_i) begin
    init_q <= init_i;
    if (rst_i) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StClear: begin
          if (restart) begin
            cnt_q <= '0;
          end else if (last_idx) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StIdle: begin
          if (init_i) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          state_q <= StClear;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= StClear;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    up_gnt_o    = 1'b0;
    ram_req_o   = '0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_be_o    = '0;
    busy_o      = 1'b1;
    done_o      = 1'b0;

    unique case (state_q)
      StClear: begin
        ram_req_o  = '1;
        ram_we_o   = 1'b1;
        ram_addr_o = cnt_q;
        ram_be_o   = '1;
        done_o     = last_idx & ~restart;
      end
      StIdle: begin
        // A pending init blocks the grant so the following drain cycle only
        // has to cover reads granted before it.
        if (!init_i) begin
          up_gnt_o    = |up_req_i;
          ram_req_o   = up_req_i;
          ram_we_o    = up_we_i;
          ram_addr_o  = up_addr_i;
          ram_wdata_o = up_wdata_i;
          ram_be_o    = up_be_i;
          busy_o      = 1'b0;
        end
      end
      default: ;
    endcase

    if (rst_i) begin
      up_gnt_o  = 1'b0;
      ram_req_o = '0;
      ram_we_o  = 1'b0;
      busy_o    = 1'b1;
      done_o    = 1'b0;
    end
  end

endmodule

// File: tb/tb_dcache_vldrty_init.sv
// Directed bench for the valid/dirty init sequencer at 256 words x 8 ways.
module tb_dcache_vldrty_init;
  import std_cache_pkg::*;

  localparam int unsigned NumWords = 256;
  localparam int unsigned SetAssoc = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   init;
  logic [SetAssoc-1:0]    up_req;
  logic                   up_we;
  logic [7:0]             up_addr;
  vldrty_t [SetAssoc-1:0] up_wdata;
  vldrty_t [SetAssoc-1:0] up_be;
  logic                   up_gnt;
  logic [SetAssoc-1:0]    ram_req;
  logic                   ram_we;
  logic [7:0]             ram_addr;
  vldrty_t [SetAssoc-1:0] ram_wdata;
  vldrty_t [SetAssoc-1:0] ram_be;
  logic                   busy;
  logic                   done;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  dcache_vldrty_init #(
    .NumWords (NumWords),
    .SetAssoc (SetAssoc)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .init_i      (init),
    .up_req_i    (up_req),
    .up_we_i     (up_we),
    .up_addr_i   (up_addr),
    .up_wdata_i  (up_wdata),
    .up_be_i     (up_be),
    .up_gnt_o    (up_gnt),
    .ram_req_o   (ram_req),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_be_o    (ram_be),
    .busy_o      (busy),
    .done_o      (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_forced(input string tag);
    chk({tag, " req"},  32'(ram_req), 32'h0);
    chk({tag, " we"},   32'(ram_we),  32'h0);
    chk({tag, " gnt"},  32'(up_gnt),  32'h0);
    chk({tag, " busy"}, 32'(busy),    32'h1);
    chk({tag, " done"}, 32'(done),    32'h0);
  endtask

  // Full 256-write clear starting at the current cycle; returns one cycle past it.
  task automatic clear_run(input string tag);
    for (int k = 0; k < int'(NumWords); k++) begin
      chk({tag, " addr"}, 32'(ram_addr), 32'(k));
      chk({tag, " we"},   32'(ram_we),   32'h1);
      chk({tag, " req"},  32'(ram_req),  32'hFF);
      chk({tag, " gnt"},  32'(up_gnt),   32'h0);
      chk({tag, " busy"}, 32'(busy),     32'h1);
      chk({tag, " done"}, 32'(done),     32'(k == int'(NumWords) - 1));
      if (k == 0) begin
        chk({tag, " be"},    32'(ram_be),    32'hFFFF);
        chk({tag, " wdata"}, 32'(ram_wdata), 32'h0);
      end
      tick();
    end
  endtask

  initial begin
    rst      = 1'b1;
    init     = 1'b0;
    up_req   = 8'hFF;
    up_we    = 1'b1;
    up_addr  = 8'h11;
    up_wdata = 16'hFFFF;
    up_be    = 16'hFFFF;

    // Reset, then the boot-time clear.
    tick();
    chk_forced("rst0");
    tick();
    chk_forced("rst1");
    rst = 1'b0;
    #1;
    clear_run("boot");

    // Idle pass-through.
    up_req   = 8'h04;
    up_we    = 1'b1;
    up_addr  = 8'h3A;
    up_wdata = 16'h0030;
    up_be    = 16'h00F0;
    #1;
    chk("pt req",   32'(ram_req),   32'h04);
    chk("pt we",    32'(ram_we),    32'h1);
    chk("pt addr",  32'(ram_addr),  32'h3A);
    chk("pt wdata", 32'(ram_wdata), 32'h0030);
    chk("pt be",    32'(ram_be),    32'h00F0);
    chk("pt gnt",   32'(up_gnt),    32'h1);
    chk("pt busy",  32'(busy),      32'h0);
    up_req = 8'h00;
    #1;
    chk("pt nognt", 32'(up_gnt), 32'h0);
    tick();

    // Read at t, init at t+1, drain at t+2, clear from t+3.
    up_req  = 8'h01;
    up_we   = 1'b0;
    up_addr = 8'd5;
    #1;
    chk("rd gnt",  32'(up_gnt),   32'h1);
    chk("rd req",  32'(ram_req),  32'h01);
    chk("rd addr", 32'(ram_addr), 32'h5);
    chk("rd we",   32'(ram_we),   32'h0);
    tick();
    init = 1'b1;
    #1;
    chk("ini gnt",  32'(up_gnt),  32'h0);
    chk("ini req",  32'(ram_req), 32'h0);
    chk("ini busy", 32'(busy),    32'h1);
    tick();
    init = 1'b0;
    #1;
    chk("drn req",  32'(ram_req), 32'h0);
    chk("drn we",   32'(ram_we),  32'h0);
    chk("drn gnt",  32'(up_gnt),  32'h0);
    chk("drn busy", 32'(busy),    32'h1);
    tick();
    clear_run("rdinit");
    chk("rdinit idle gnt",  32'(up_gnt), 32'h1);
    chk("rdinit idle busy", 32'(busy),   32'h0);

    // Init pulse when cnt reaches 100 restarts the sweep.
    up_req = 8'h00;
    init   = 1'b1;
    tick();
    init = 1'b0;
    tick();
    for (int k = 0; k < 100; k++) tick();
    chk("mid addr", 32'(ram_addr), 32'd100);
    init = 1'b1;
    #1;
    chk("mid we",   32'(ram_we),   32'h1);
    chk("mid addr", 32'(ram_addr), 32'd100);
    chk("mid done", 32'(done),     32'h0);
    tick();
    init = 1'b0;
    clear_run("reinit");
    chk("reinit idle", 32'(busy), 32'h0);

    // Reset at cnt 50 forces idle outputs and restarts from 0.
    up_req = 8'hFF;
    init   = 1'b1;
    tick();
    init = 1'b0;
    tick();
    for (int k = 0; k < 50; k++) tick();
    chk("mrst addr", 32'(ram_addr), 32'd50);
    rst = 1'b1;
    #1;
    chk_forced("mrst a");
    tick();
    chk_forced("mrst b");
    tick();
    chk_forced("mrst c");
    rst = 1'b0;
    #1;
    clear_run("mrst");
    chk("mrst idle gnt", 32'(up_gnt), 32'h1);

    // Held init: one idle cycle between done and the next drain.
    init = 1'b1;
    #1;
    chk("cont idle0 busy", 32'(busy),   32'h1);
    chk("cont idle0 gnt",  32'(up_gnt), 32'h0);
    tick();
    chk("cont drn0 req", 32'(ram_req), 32'h0);
    tick();
    clear_run("cont1");
    chk("cont idle1 busy", 32'(busy),    32'h1);
    chk("cont idle1 gnt",  32'(up_gnt),  32'h0);
    chk("cont idle1 req",  32'(ram_req), 32'h0);
    chk("cont idle1 done", 32'(done),    32'h0);
    tick();
    chk("cont drn1 req",  32'(ram_req), 32'h0);
    chk("cont drn1 busy", 32'(busy),    32'h1);
    tick();
    init = 1'b0;
    #1;
    clear_run("cont2");
    chk("cont end busy", 32'(busy),   32'h0);
    chk("cont end gnt",  32'(up_gnt), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
